// File: rtl/led_panel_pkg.sv
// Shared types and constants for the LED panel scan sequencer.
// Holds the scan state encoding, column phase encoding and panel control defaults.
package led_panel_pkg;

  localparam int ROW_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_CLK,
    ST_BLANK,
    ST_ADVANCE,
    ST_LATCH,
    ST_DWELL
  } scan_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_FETCH,
    PH_SETUP,
    PH_CLK
  } col_phase_e;

  typedef struct packed {
    logic blank;
    logic latch;
    logic aclk;
    logic arst;
    logic frame;
  } panel_ctl_t;

  // Panel dark, no strobes: used in IDLE and as the reset value.
  localparam panel_ctl_t CTL_IDLE = '{blank: 1'b1, latch: 1'b0, aclk: 1'b0, arst: 1'b0, frame: 1'b0};
  localparam panel_ctl_t CTL_LIT  = '{blank: 1'b0, latch: 1'b0, aclk: 1'b0, arst: 1'b0, frame: 1'b0};

  function automatic logic [ROW_W-1:0] next_row_f(input logic [ROW_W-1:0] ptr,
                                                   input logic [ROW_W-1:0] rowmax);
    return (ptr >= rowmax) ? '0 : ptr + ROW_W'(1);
  endfunction

endpackage

// File: rtl/led_panel_col_shifter.sv
// Column engine: FETCH / SETUP / CLK per column, COLS columns per start pulse.
// Data is captured at the end of FETCH and held through SETUP and the sclk-high CLK cycle.
module led_panel_col_shifter
  import led_panel_pkg::*;
#(
  parameter int COLS  = 32,
  parameter int COL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       pix_i,
  output logic             done_o,
  output logic [COL_W-1:0] col_o,
  output logic [2:0]       data_o,
  output logic             sclk_o
);

  col_phase_e       ph_q, ph_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [2:0]       data_q, data_d;
  logic             sclk_q, sclk_d;
  logic             last_col;

  assign last_col = (col_q == COL_W'(COLS - 1));
  assign done_o   = (ph_q == PH_CLK) && last_col;

  always_comb begin
    ph_d   = ph_q;
    col_d  = col_q;
    data_d = data_q;
    case (ph_q)
      PH_IDLE: begin
        if (start_i) begin
          ph_d  = PH_FETCH;
          col_d = '0;
        end
      end
      PH_FETCH: begin
        ph_d   = PH_SETUP;
        data_d = pix_i;
      end
      PH_SETUP: ph_d = PH_CLK;
      PH_CLK: begin
        if (last_col) begin
          // Park at column 0 with data cleared so the row tail and IDLE show zeros.
          ph_d   = PH_IDLE;
          col_d  = '0;
          data_d = '0;
        end else begin
          ph_d  = PH_FETCH;
          col_d = col_q + COL_W'(1);
        end
      end
      default: ph_d = PH_IDLE;
    endcase
    sclk_d = (ph_d == PH_CLK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q   <= PH_IDLE;
      col_q  <= '0;
      data_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      col_q  <= col_d;
      data_q <= data_d;
      sclk_q <= sclk_d;
    end
  end

  assign col_o  = col_q;
  assign data_o = data_q;
  assign sclk_o = sclk_q;

endmodule

// File: rtl/led_panel_scan_ctrl.sv
// Row-slot scheduler for the LED panel: shift a row in, blank, advance address,
// latch, dwell. Outputs are registered from the next-state decode.
module led_panel_scan_ctrl
  import led_panel_pkg::*;
#(
  parameter int COLS      = 32,
  parameter int COL_W     = 5,
  parameter int ON_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ROW_W-1:0] rowmax_in,
  input  logic             pix_r,
  input  logic             pix_g,
  input  logic             pix_b,
  output logic [COL_W-1:0] col_out,
  output logic [ROW_W-1:0] row_out,
  output logic             red_out,
  output logic             green_out,
  output logic             blue_out,
  output logic             sclk_out,
  output logic             latch_out,
  output logic             blank_out,
  output logic             aclk_out,
  output logic             arst_out,
  output logic             frame_start_out
);

  localparam int DW_W = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;

  scan_state_e      state_q, state_d;
  logic [ROW_W-1:0] row_ptr_q, row_ptr_d;
  logic [ROW_W-1:0] next_row_q, next_row_d;
  logic [ROW_W-1:0] next_row_c;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic             first_q, first_d;
  panel_ctl_t       ctl_q, ctl_d;
  logic             start;
  logic             shift_done;
  logic             dwell_last;
  logic [2:0]       shift_data;

  assign next_row_c = next_row_f(row_ptr_q, rowmax_in);
  assign dwell_last = (dwell_q == DW_W'(ON_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    row_ptr_d  = row_ptr_q;
    next_row_d = next_row_q;
    dwell_d    = dwell_q;
    first_d    = first_q;
    start      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          // Pointer starts at the last row so the first slot wraps to row 0.
          state_d    = ST_FETCH;
          row_ptr_d  = rowmax_in;
          next_row_d = '0;
          first_d    = 1'b1;
          start      = 1'b1;
        end
      end
      ST_FETCH:   state_d = ST_SETUP;
      ST_SETUP:   state_d = ST_CLK;
      ST_CLK:     state_d = shift_done ? ST_BLANK : ST_FETCH;
      ST_BLANK:   state_d = ST_ADVANCE;
      ST_ADVANCE: begin
        state_d   = ST_LATCH;
        row_ptr_d = next_row_q;
      end
      ST_LATCH: begin
        state_d = ST_DWELL;
        dwell_d = '0;
        first_d = 1'b0;
      end
      ST_DWELL: begin
        if (dwell_last) begin
          if (enable) begin
            state_d    = ST_FETCH;
            next_row_d = next_row_c;
            start      = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            next_row_d = '0;
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ctl_d = CTL_IDLE;
    case (state_d)
      // The previous row stays lit while shifting, except on the first slot after IDLE.
      ST_FETCH, ST_SETUP, ST_CLK: ctl_d.blank = first_d;
      ST_ADVANCE: begin
        ctl_d.arst  = (next_row_d == '0);
        ctl_d.frame = (next_row_d == '0);
        ctl_d.aclk  = (next_row_d != '0);
      end
      ST_LATCH: ctl_d.latch = 1'b1;
      ST_DWELL: ctl_d = CTL_LIT;
      default:  ctl_d = CTL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      row_ptr_q  <= '0;
      next_row_q <= '0;
      dwell_q    <= '0;
      first_q    <= 1'b0;
      ctl_q      <= CTL_IDLE;
    end else begin
      state_q    <= state_d;
      row_ptr_q  <= row_ptr_d;
      next_row_q <= next_row_d;
      dwell_q    <= dwell_d;
      first_q    <= first_d;
      ctl_q      <= ctl_d;
    end
  end

  led_panel_col_shifter #(
    .COLS  (COLS),
    .COL_W (COL_W)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (start),
    .pix_i   ({pix_r, pix_g, pix_b}),
    .done_o  (shift_done),
    .col_o   (col_out),
    .data_o  (shift_data),
    .sclk_o  (sclk_out)
  );

  assign row_out         = next_row_q;
  assign red_out         = shift_data[2];
  assign green_out       = shift_data[1];
  assign blue_out        = shift_data[0];
  assign blank_out       = ctl_q.blank;
  assign latch_out       = ctl_q.latch;
  assign aclk_out        = ctl_q.aclk;
  assign arst_out        = ctl_q.arst;
  assign frame_start_out = ctl_q.frame;

endmodule

// File: doc/led_panel_scan_ctrl.md
Name: led_panel_scan_ctrl

Overview:
- Scan sequencer for the single-colour-plane LED panel.
- Per row slot: fetches COLS pixels from an external pixel source and shifts them out on red/green/blue with sclk, then blanks the panel, advances the row address (aclk, or arst on wrap), latches, and dwells.
- Sits between the frame/pixel source and the panel pins.
- Replaces the free-running pattern logic inside the panel driver with a handshake-driven scheduler.

Parameters:
- COLS, 32, columns shifted per row; must be at least 2.
- COL_W, 5, column index width; must satisfy 2^COL_W >= COLS.
- ON_CYCLES, 64, DWELL length in clk cycles; must be at least 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset; asynchronous, active-low.
- enable  input  1  run request; sampled in IDLE and at the end of each DWELL.
- rowmax_in  input  3  index of the last panel row (rows 0..rowmax_in).
- pix_r / pix_g / pix_b  input  1 each  pixel for (row_out, col_out); combinational from the source and valid within the FETCH cycle.
- col_out  output  COL_W  requested column.
- row_out  output  3  requested row, equal to next_row.
- red_out / green_out / blue_out  output  1 each  panel serial data.
- sclk_out  output  1  panel shift clock.
- latch_out  output  1  panel latch.
- blank_out  output  1  panel blank, active-high.
- aclk_out  output  1  row address increment.
- arst_out  output  1  row address reset.
- frame_start_out  output  1  one-cycle pulse when row 0 becomes displayed.

Behaviour:
- All outputs are registered.
- Async reset values:
  - state=IDLE, blank_out=1.
  - All other outputs 0.
  - row_ptr=0, col=0, dwell counter=0.
- States: IDLE, FETCH, SETUP, CLK, BLANK, ADVANCE, LATCH, DWELL.
- IDLE:
  - blank_out=1, everything else 0.
  - If enable=1: row_ptr<=rowmax_in, col<=0, go to FETCH.
- next_row rule: next_row = (row_ptr >= rowmax_in) ? 0 : row_ptr+1.
  - Evaluated combinationally.
  - Captured into a register on entry to the first FETCH of a slot.
  - A rowmax_in change mid-slot only takes effect at the next slot.
- FETCH (1 cycle):
  - col_out=col, row_out=next_row, sclk_out=0.
  - At the end of the cycle, {red,green,blue}_out <= {pix_r,pix_g,pix_b}.
- SETUP (1 cycle): sclk_out=0; data held stable.
- CLK (1 cycle):
  - sclk_out=1; data held.
  - If col==COLS-1: go to BLANK and clear data outputs to 0.
  - Else: col<=col+1, go to FETCH.
- blank_out is 0 throughout FETCH/SETUP/CLK, so the previous row stays lit while the next row shifts in. On the very first slot after IDLE, blank stays 1 until the first DWELL.
- BLANK (1 cycle): blank_out=1.
- ADVANCE (1 cycle):
  - blank_out=1.
  - If next_row==0: arst_out=1 and frame_start_out=1; else aclk_out=1.
  - row_ptr<=next_row.
- LATCH (1 cycle): blank_out=1, latch_out=1.
- DWELL (ON_CYCLES cycles):
  - blank_out=0; counter runs 0..ON_CYCLES-1.
  - On the last cycle: if enable=1 go to FETCH with col<=0; else go to IDLE, where blank_out=1.
- Slot length is 3*COLS + 3 + ON_CYCLES cycles: 163 at defaults, 23 with COLS=4 and ON_CYCLES=8.
- Pulses:
  - latch_out, aclk_out and arst_out are never high in the same cycle.
  - Each is exactly 1 cycle wide.
  - sclk_out is exactly 1 cycle high per column, with data stable for 1 cycle before and during the high cycle.
- A deassert of enable mid-slot is ignored until the DWELL end; a slot always completes.
- rowmax_in=0 gives a single-row panel: every slot uses arst_out, and frame_start_out pulses every slot.
- Async reset mid-slot: outputs drop to their reset values immediately; sclk, latch, aclk and arst go low at once, and blank_out goes to 1.

Decomposition:
- Package led_panel_pkg holds:
  - the scan state enum;
  - row index width ROW_W=3;
  - the blank/idle output default constants.
- One natural sub-module, led_panel_col_shifter: the FETCH/SETUP/CLK column engine.
  - Inputs: start.
  - Outputs: done, col_out, data, sclk.
- The top FSM handles BLANK/ADVANCE/LATCH/DWELL and the row pointer.

Test Plan:
- Reset then enable=1, rowmax_in=3, COLS=4, ON_CYCLES=8:
  - First slot has row_out=0, col_out 0,1,2,3 in FETCH cycles, 4 sclk pulses, then arst_out plus frame_start_out, then latch_out.
  - blank_out=0 for 8 cycles; slot length is 23 cycles.
- Pixel source returns pix_r=col[0]: red_out at each sclk_out high reads 0,1,0,1, stable in the SETUP and CLK cycles.
- Run 5 slots with rowmax_in=3:
  - Advance pulses are arst, aclk, aclk, aclk, arst.
  - row_out is 0,1,2,3,0, and frame_start_out pulses in slots 1 and 5.
- At cycle 5 of slot 2, drop rowmax_in from 3 to 0 (pointer at 1):
  - Slot 2 still shows row 1 with aclk_out.
  - Slot 3 uses arst_out with row_out=0.
- Deassert enable mid-shift: the slot completes through DWELL, then IDLE with blank_out=1 and no further sclk_out.
- Assert reset low during CLK: sclk_out=0 and blank_out=1 within the same cycle. After release with enable=1, the restart begins with row 0 via arst_out.
